mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline, directly downstream of the EX/MEM pipeline register; consumes its outputs unchanged.
- Performs loads/stores over a req/ack data-memory port, aligns store data and byte enables, extracts and extends load data, selects write-back data, and registers the result into the MEM/WB outputs.
- Raises stall_o while an access is outstanding; the hazard unit uses it to freeze PC, IF/ID, ID/EX and EX/MEM.

Parameters:
- TIMEOUT, 255, ACCESS-state cycles without ack before bus_err_o; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- valid_i  in  1  EX/MEM slot holds a real instruction.
- advance_pc_i  in  32  PC+4 from EX/MEM.
- alu_result_i  in  32  ALU result / effective address.
- reg_2_data_i  in  32  store data (rs2).
- reg_write_i  in  1  instruction writes rd.
- rd_i  in  5  destination register.
- mem_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_sign_extend_i  in  1  sign-extend loads when 1.
- reg_src_i  in  2  00 ALU, 01 memory, 10 advance_pc, 11 ALU.
- mem_write_i  in  1  store.
- dmem_req_o  out  1  access request, held until ack.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  32  word address, {alu_result_i[31:2],2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_ack_i  in  1  one-cycle completion; rdata valid the same cycle.
- dmem_rdata_i  in  32  read word.
- stall_o  out  1  freeze upstream stages.
- valid_o  out  1  MEM/WB valid.
- wb_data_o  out  32  MEM/WB write-back data.
- reg_write_o  out  1  MEM/WB register write enable.
- rd_o  out  5  MEM/WB destination.
- misalign_o  out  1  one-cycle pulse, misaligned access dropped.
- bus_err_o  out  1  one-cycle pulse, access timed out.

Behaviour:
- mem op = valid_i & (mem_write_i | reg_src_i==01). Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Reset (rst_n=0 at posedge): state IDLE, counter 0, dmem_req_o=0, and every registered output (valid_o, wb_data_o, reg_write_o, rd_o, misalign_o, bus_err_o) = 0. This aborts any in-flight access; ack arriving in IDLE is ignored.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no mem op: stall_o=0; MEM/WB captures next edge (latency 1). wb_data is alu_result or advance_pc per reg_src. valid_o=valid_i. reg_write_o=valid_i&reg_write_i.
- IDLE, mem op, misaligned: no request, stall_o=0; MEM/WB captures a bubble with reg_write_o=0; misalign_o=1 for one cycle.
- IDLE, mem op, aligned: stall_o=1, MEM/WB captures a bubble, go to ACCESS.
- ACCESS: dmem_req_o=1; we/addr/be/wdata are driven from the held inputs and stay stable; stall_o=1; MEM/WB captures a bubble; counter increments each cycle.
  - On ack: latch rdata (loads), clear counter, go to DONE.
  - Counter reaching TIMEOUT (TIMEOUT>0) with no ack: drop req, pulse bus_err_o, go to DONE with the load result forced to 0 and reg_write suppressed.
- DONE: stall_o=0; MEM/WB captures the result (load data for loads; store gives reg_write_o=0); return to IDLE. Minimum memory-op latency is 3 cycles.
- Store lanes:
  - byte: wdata={4{rs2[7:0]}}, be=0001<<addr[1:0].
  - half: wdata={2{rs2[15:0]}}, be=0011<<{addr[1],1'b0}.
  - word: be=1111.
- Load extract: shift rdata right by 8*addr[1:0], then zero- or sign-extend bits [7:0] or [15:0]; word is passed unchanged.
- valid_i=0: treated as a bubble, never a memory op.

Decomposition:
- Shared package holds:
  - mem_width encodings.
  - reg_src encodings.
  - FSM state enum.
- One sub-module, mem_align_unit (combinational store-lane and load-extract logic), so it can be unit-tested separately.

Test Plan:
- ALU op, alu_result=0x1234, reg_src=00, reg_write=1, rd=5: next cycle valid_o=1, wb_data_o=0x1234, rd_o=5, stall_o never high.
- lb at addr 0x103, sign_extend=1, ack after 2 ACCESS cycles with rdata=0x80FFFFFF: stall_o high 3 cycles; wb_data_o=0xFFFFFF80. Same with sign_extend=0 gives 0x00000080.
- sh rs2=0xABCD at addr 0x202: dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_addr_o=0x200; reg_write_o=0 in the DONE output.
- lw at addr 0x101: no dmem_req_o; misalign_o pulses once; reg_write_o=0; stall_o stays 0.
- TIMEOUT=4, load never acked: bus_err_o pulses after 4 ACCESS cycles; wb_data_o=0; reg_write_o=0; pipeline resumes.
- rst_n low during ACCESS, with ack arriving the cycle after reset: dmem_req_o=0 and all outputs 0 at the reset edge; the late ack produces no write-back.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access widths, write-back source select
// and the access FSM states.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    WIDTH_BYTE     = 2'b00,
    WIDTH_HALF     = 2'b01,
    WIDTH_WORD     = 2'b10,
    WIDTH_WORD_ALT = 2'b11
  } mem_width_e;

  typedef enum logic [1:0] {
    SRC_ALU     = 2'b00,
    SRC_MEM     = 2'b01,
    SRC_PC      = 2'b10,
    SRC_ALU_ALT = 2'b11
  } reg_src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_access_stage_align_unit.sv
// Combinational byte-lane steering for stores and lane extraction/extension
// for loads, plus the misalignment check for the access width.
module mem_align_unit
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  width_i,
  input  logic        sign_extend_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted      = rdata_i >> {addr_lo_i, 3'b000};
    be_o         = 4'b1111;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    case (width_i)
      WIDTH_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{sign_extend_i & shifted[7]}}, shifted[7:0]};
      end
      WIDTH_HALF: begin
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{store_data_i[15:0]}};
        load_data_o  = {{16{sign_extend_i & shifted[15]}}, shifted[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      // Both word encodings pass the read word through untouched.
      default: misaligned_o = (addr_lo_i != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over the dmem req/ack port, stalls upstream while
// an access is outstanding, and registers the MEM/WB result.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] advance_pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] reg_2_data_i,
  input  logic        reg_write_i,
  input  logic [4:0]  rd_i,
  input  logic [1:0]  mem_width_i,
  input  logic        mem_sign_extend_i,
  input  logic [1:0]  reg_src_i,
  input  logic        mem_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] wb_data_o,
  output logic        reg_write_o,
  output logic [4:0]  rd_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [31:0]       wb_q, wb_d;
  logic              rw_q, rw_d;
  logic [4:0]        rd_q, rd_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  logic              mem_op, is_load, misaligned, timeout;
  logic [31:0]       load_data, alu_or_pc;

  mem_align_unit u_align (
    .addr_lo_i     (alu_result_i[1:0]),
    .width_i       (mem_width_i),
    .sign_extend_i (mem_sign_extend_i),
    .store_data_i  (reg_2_data_i),
    .rdata_i       (rdata_q),
    .be_o          (dmem_be_o),
    .wdata_o       (dmem_wdata_o),
    .load_data_o   (load_data),
    .misaligned_o  (misaligned)
  );

  // Handshake: dmem_req_o rises on entry to ACCESS and holds, with we/addr/be/wdata
  // stable, until dmem_ack_i is seen high for one cycle (rdata valid that cycle)
  // or the timeout expires; ack outside ACCESS is ignored.
  assign mem_op      = valid_i && (mem_write_i || reg_src_i == SRC_MEM);
  assign is_load     = !mem_write_i && reg_src_i == SRC_MEM;
  assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout     = (TIMEOUT != 0) && (cnt_inc == TO_LIMIT);
  assign alu_or_pc   = (reg_src_i == SRC_PC) ? advance_pc_i : alu_result_i;
  assign dmem_we_o   = mem_write_i;
  assign dmem_addr_o = {alu_result_i[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    wb_d       = '0;
    rw_d       = 1'b0;
    rd_d       = '0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_op) begin
          valid_d = valid_i;
          wb_d    = alu_or_pc;
          rw_d    = valid_i & reg_write_i;
          rd_d    = rd_i;
        end else if (misaligned) begin
          mis_d = 1'b1;
        end else begin
          stall_o = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        cnt_d      = cnt_inc[CNT_W-1:0];
        if (dmem_ack_i) begin
          rdata_d = dmem_rdata_i;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          berr_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_d = valid_i;
        rd_d    = rd_i;
        state_d = ST_IDLE;
        if (is_load) begin
          wb_d = err_q ? '0 : load_data;
          rw_d = valid_i & reg_write_i & !err_q;
        end else begin
          wb_d = alu_or_pc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      wb_q    <= '0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      wb_q    <= wb_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign valid_o     = valid_q;
  assign wb_data_o   = wb_q;
  assign reg_write_o = rw_q;
  assign rd_o        = rd_q;
  assign misalign_o  = mis_q;
  assign bus_err_o   = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized operations checked against a behavioural model.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk, rst_n;
  logic        valid_i, reg_write_i, mem_sign_extend_i, mem_write_i, dmem_ack_i;
  logic [31:0] advance_pc_i, alu_result_i, reg_2_data_i, dmem_rdata_i;
  logic [4:0]  rd_i;
  logic [1:0]  mem_width_i, reg_src_i;
  logic        dmem_req_o, dmem_we_o, stall_o, valid_o, reg_write_o, misalign_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  rd_o;

  int checks   = 0;
  int failures = 0;
  logic [38:0] exp_q[$];

  mem_access_stage #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .advance_pc_i(advance_pc_i),
    .alu_result_i(alu_result_i), .reg_2_data_i(reg_2_data_i), .reg_write_i(reg_write_i),
    .rd_i(rd_i), .mem_width_i(mem_width_i), .mem_sign_extend_i(mem_sign_extend_i),
    .reg_src_i(reg_src_i), .mem_write_i(mem_write_i), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .valid_o(valid_o), .wb_data_o(wb_data_o), .reg_write_o(reg_write_o),
    .rd_o(rd_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: load value seen by the register file.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] a,
                                             input logic [1:0] w, input logic sx);
    logic [31:0] v;
    v = rdata >> (32'd8 * 32'(a));
    if (w == 2'd0) begin
      v = v % 32'd256;
      if (sx && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = v % 32'd65536;
      if (sx && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    valid_i = 1'b0; mem_write_i = 1'b0; reg_src_i = 2'b00; reg_write_i = 1'b0;
  endtask

  // Driver + checker for one instruction. ack_delay = ACCESS cycle carrying ack, 0 = never.
  task automatic do_op(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic rw, input logic [4:0] rd,
                       input logic [1:0] w, input logic sx, input logic [1:0] src,
                       input logic we, input int ack_delay, input logic [31:0] rdata,
                       input string tag);
    logic        memop, mis, tmo, chk_wb, exp_valid, exp_rw;
    logic [1:0]  a, ew;
    logic [31:0] exp_wb, exp_be, exp_wd;
    logic [38:0] pkt;
    int          exp_stall, exp_req, stall_cnt, req_cnt, mis_cnt, berr_cnt;
    bit          done;

    a      = alu[1:0];
    ew     = (w == 2'b11) ? 2'b10 : w;
    memop  = v && (we || src == 2'b01);
    mis    = memop && ((ew == 2'd1 && a[0]) || (ew == 2'd2 && a != 2'd0));
    tmo    = memop && !mis && ack_delay == 0;
    exp_stall = 0; exp_req = 0; chk_wb = 1'b0;
    exp_be = (ew == 2'd0) ? (32'd1 << a) : (ew == 2'd1) ? (32'd3 << a) : 32'd15;
    exp_wd = (ew == 2'd0) ? 32'(rs2[7:0]) * 32'h0101_0101 :
             (ew == 2'd1) ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
    if (!memop) begin
      exp_valid = v; exp_rw = v && rw; exp_wb = (src == 2'b10) ? pc : alu; chk_wb = v;
    end else if (mis) begin
      exp_valid = 1'b0; exp_rw = 1'b0; exp_wb = '0;
    end else begin
      exp_valid = 1'b1;
      exp_req   = tmo ? TMO : ack_delay;
      exp_stall = 1 + exp_req;
      if (we) begin
        exp_rw = 1'b0; exp_wb = '0;
      end else if (tmo) begin
        exp_rw = 1'b0; exp_wb = '0; chk_wb = 1'b1;
      end else begin
        exp_rw = rw; exp_wb = model_load(rdata, a, ew, sx); chk_wb = 1'b1;
      end
    end
    exp_q.push_back({exp_valid, exp_rw, rd, exp_wb});

    @(negedge clk);
    valid_i = v; advance_pc_i = pc; alu_result_i = alu; reg_2_data_i = rs2; reg_write_i = rw;
    rd_i = rd; mem_width_i = w; mem_sign_extend_i = sx; reg_src_i = src; mem_write_i = we;
    stall_cnt = 0; req_cnt = 0; mis_cnt = 0; berr_cnt = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (stall_o === 1'b1) stall_cnt++;
      if (misalign_o === 1'b1) mis_cnt++;
      if (bus_err_o === 1'b1) berr_cnt++;
      if (dmem_req_o === 1'b1) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check({tag, ".addr"}, dmem_addr_o, {alu[31:2], 2'b00});
          check({tag, ".we"}, 32'(dmem_we_o), 32'(we));
          if (we) begin
            check({tag, ".be"}, 32'(dmem_be_o), exp_be);
            check({tag, ".wdata"}, dmem_wdata_o, exp_wd);
          end
        end
        if (req_cnt == ack_delay) begin
          dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        end
      end
      if (stall_o !== 1'b1) done = 1;
      @(posedge clk); #1;
      dmem_ack_i = 1'b0;
      @(negedge clk);
    end
    if (!done) check({tag, ".completed"}, 32'd0, 32'd1);
    #1;
    if (misalign_o === 1'b1) mis_cnt++;
    if (bus_err_o === 1'b1) berr_cnt++;
    pkt = exp_q.pop_front();
    check({tag, ".valid"}, 32'(valid_o), 32'(pkt[38]));
    check({tag, ".reg_write"}, 32'(reg_write_o), 32'(pkt[37]));
    if (pkt[38]) check({tag, ".rd"}, 32'(rd_o), 32'(pkt[36:32]));
    if (chk_wb) check({tag, ".wb_data"}, wb_data_o, pkt[31:0]);
    idle_inputs();
    @(negedge clk); #1;
    if (misalign_o === 1'b1) mis_cnt++;
    if (bus_err_o === 1'b1) berr_cnt++;
    check({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    check({tag, ".req_cycles"}, 32'(req_cnt), 32'(exp_req));
    check({tag, ".misalign_pulses"}, 32'(mis_cnt), 32'(mis));
    check({tag, ".bus_err_pulses"}, 32'(berr_cnt), 32'(tmo));
  endtask

  initial begin
    logic        v, rw, sx, we;
    logic [1:0]  w, src;
    logic [31:0] alu, rdata;
    int          kind, dly;

    rst_n = 1'b0; idle_inputs();
    advance_pc_i = '0; alu_result_i = '0; reg_2_data_i = '0; rd_i = '0;
    mem_width_i = '0; mem_sign_extend_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.req", 32'(dmem_req_o), 32'd0);
    check("reset.stall", 32'(stall_o), 32'd0);
    check("reset.valid", 32'(valid_o), 32'd0);
    check("reset.wb_data", wb_data_o, 32'd0);
    check("reset.reg_write", 32'(reg_write_o), 32'd0);
    check("reset.rd", 32'(rd_o), 32'd0);
    check("reset.misalign", 32'(misalign_o), 32'd0);
    check("reset.bus_err", 32'(bus_err_o), 32'd0);
    rst_n = 1'b1;

    // Directed scenarios
    do_op(1, 32'h104, 32'h1234, 32'h0, 1, 5'd5, 2'b10, 0, 2'b00, 0, 1, 32'h0, "alu_op");
    do_op(1, 32'h108, 32'h0000_0103, 32'h0, 1, 5'd6, 2'b00, 1, 2'b01, 0, 2, 32'h80FF_FFFF, "lb_sx");
    do_op(1, 32'h10C, 32'h0000_0103, 32'h0, 1, 5'd6, 2'b00, 0, 2'b01, 0, 2, 32'h80FF_FFFF, "lbu");
    do_op(1, 32'h110, 32'h0000_0202, 32'hABCD, 1, 5'd0, 2'b01, 0, 2'b00, 1, 1, 32'h0, "sh");
    do_op(1, 32'h114, 32'h0000_0101, 32'h0, 1, 5'd9, 2'b10, 0, 2'b01, 0, 1, 32'h0, "lw_misalign");
    do_op(1, 32'h118, 32'h0000_0400, 32'h0, 1, 5'd10, 2'b10, 0, 2'b01, 0, 0, 32'h1234_5678, "lw_timeout");
    do_op(1, 32'h11C, 32'h0000_0040, 32'h0, 1, 5'd11, 2'b10, 0, 2'b10, 0, 1, 32'h0, "jal_pc");
    do_op(1, 32'h120, 32'h0000_0402, 32'h0, 1, 5'd12, 2'b01, 1, 2'b01, 0, TMO, 32'h8001_7FFF, "lh_ack_at_limit");

    // Reset during ACCESS with ack arriving just after
    @(negedge clk);
    valid_i = 1'b1; reg_src_i = 2'b01; mem_write_i = 1'b0; mem_width_i = 2'b10;
    alu_result_i = 32'h400; reg_write_i = 1'b1; rd_i = 5'd7;
    @(negedge clk); #1;
    check("rst_abort.req_before", 32'(dmem_req_o), 32'd1);
    rst_n = 1'b0; idle_inputs();
    @(posedge clk); #1;
    check("rst_abort.req", 32'(dmem_req_o), 32'd0);
    check("rst_abort.stall", 32'(stall_o), 32'd0);
    check("rst_abort.valid", 32'(valid_o), 32'd0);
    check("rst_abort.reg_write", 32'(reg_write_o), 32'd0);
    check("rst_abort.wb_data", wb_data_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    check("rst_abort.late_ack_req", 32'(dmem_req_o), 32'd0);
    @(posedge clk); #1;
    check("rst_abort.late_ack_valid", 32'(valid_o), 32'd0);
    check("rst_abort.late_ack_reg_write", 32'(reg_write_o), 32'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      v    = ($urandom_range(0, 7) != 0);
      rw   = 1'($urandom_range(0, 1));
      sx   = 1'($urandom_range(0, 1));
      w    = 2'($urandom_range(0, 3));
      alu  = $urandom;
      rdata = $urandom;
      dly  = int'($urandom_range(0, TMO));
      if (kind == 0) begin
        we = 1'b0; src = 2'($urandom_range(0, 2)); if (src == 2'b01) src = 2'b11;
      end else if (kind == 1) begin
        we = 1'b0; src = 2'b01;
      end else begin
        we = 1'b1; src = 2'($urandom_range(0, 3));
      end
      do_op(v, $urandom, alu, $urandom, rw, 5'($urandom_range(0, 31)), w, sx, src, we,
            dly, rdata, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
